// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared defaults, state encoding and digit limit for the BCD-to-binary decoder
package bcd_to_bin_seq_pkg;
    localparam int DEF_DIGITS = 10;
    localparam int DEF_BIN_W = 32;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: one accumulate step acc*10+d with range and digit checks
module bcd_digit_mac
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic [BIN_W+3:0] acc,
    input  logic [3:0]       d,
    output logic [BIN_W+3:0] acc_next,
    output logic             ovf,
    output logic             bad
);
    assign acc_next = (acc << 3) + (acc << 1) + {{BIN_W{1'b0}}, d};
    assign ovf = |acc_next[BIN_W+3:BIN_W];
    assign bad = d > BCD_MAX_DIGIT;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD to binary converter, one digit per clock, MSD first
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  overflow,
    output logic                  invalid
);
    localparam int CW = $clog2(DIGITS + 1);
    state_t state, state_n;
    logic [4*DIGITS-1:0] sr;
    logic [BIN_W+3:0] acc, acc_mac, acc_n;
    logic [CW-1:0] cnt;
    logic [3:0] d;
    logic inv_r, ovf_r, inv_n, ovf_n, step, last, m_ovf, m_bad;
    assign d = sr[4*DIGITS-1 -: 4];
    bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
        .acc(acc),
        .d(d),
        .acc_next(acc_mac),
        .ovf(m_ovf),
        .bad(m_bad)
    );
    always_comb begin
        inv_n = inv_r | m_bad;
        step = !inv_n && !ovf_r;
        ovf_n = ovf_r | (step && m_ovf);
        acc_n = (step && !m_ovf) ? acc_mac : acc;
        last = cnt == CW'(DIGITS - 1);
        state_n = state == IDLE ? (start ? CONV : IDLE) : state == CONV ? (last ? DONE : CONV) : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    assign busy = state == CONV;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
            acc <= '0;
            cnt <= '0;
            inv_r <= 1'b0;
            ovf_r <= 1'b0;
            bin <= '0;
            overflow <= 1'b0;
            invalid <= 1'b0;
        end else if (state == IDLE && start) begin
            sr <= bcd;
            acc <= '0;
            cnt <= '0;
            inv_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == CONV) begin
            sr <= {sr[4*DIGITS-5:0], 4'h0};
            acc <= acc_n;
            cnt <= cnt + 1'b1;
            inv_r <= inv_n;
            ovf_r <= ovf_n;
            if (last) begin
                bin <= inv_n ? '0 : ovf_n ? '1 : acc_n[BIN_W-1:0];
                overflow <= ovf_n;
                invalid <= inv_n;
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed scenarios for bcd_to_bin_seq with hand-computed results
module tb_bcd_to_bin_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [39:0] bcd = '0;
    logic busy, done, overflow, invalid;
    logic [31:0] bin;
    int total = 0;
    int bad = 0;

    bcd_to_bin_seq dut (
        .clk(clk), .rst(rst), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .overflow(overflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic run(input logic [39:0] v, output int lat, output int nb);
        @(negedge clk);
        bcd = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nb = 0;
        while (!done && lat < 30) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({busy, done, overflow, invalid} !== 4'b0 || bin !== 32'h0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b ovf=%b inv=%b bin=%h exp all 0", busy, done, overflow, invalid, bin);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nb;
        run(40'h0000012345, lat, nb);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL basic_latency got=%0d exp=11", lat); end
        total++;
        if (nb !== 10) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=10", nb); end
        total++;
        if (bin !== 32'h00003039 || overflow !== 1'b0 || invalid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got bin=%h ovf=%b inv=%b busy=%b exp 00003039 0 0 0", bin, overflow, invalid, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || bin !== 32'h00003039) begin
            bad++;
            $display("FAIL basic_hold got done=%b bin=%h exp done=0 bin=00003039", done, bin);
        end
    endtask

    task automatic test_boundary();
        int lat, nb;
        run(40'h4294967295, lat, nb);
        total++;
        if (bin !== 32'hFFFFFFFF || overflow !== 1'b0 || invalid !== 1'b0) begin
            bad++;
            $display("FAIL max_legal got bin=%h ovf=%b inv=%b exp FFFFFFFF 0 0", bin, overflow, invalid);
        end
        run(40'h4294967296, lat, nb);
        total++;
        if (bin !== 32'hFFFFFFFF || overflow !== 1'b1 || invalid !== 1'b0) begin
            bad++;
            $display("FAIL max_plus1 got bin=%h ovf=%b inv=%b exp FFFFFFFF 1 0", bin, overflow, invalid);
        end
        run(40'h9999999999, lat, nb);
        total++;
        if (bin !== 32'hFFFFFFFF || overflow !== 1'b1 || invalid !== 1'b0) begin
            bad++;
            $display("FAIL all_nines got bin=%h ovf=%b inv=%b exp FFFFFFFF 1 0", bin, overflow, invalid);
        end
        run(40'h0000000000, lat, nb);
        total++;
        if (bin !== 32'h0 || overflow !== 1'b0 || invalid !== 1'b0 || lat !== 11) begin
            bad++;
            $display("FAIL zero got bin=%h ovf=%b inv=%b lat=%0d exp 0 0 0 11", bin, overflow, invalid, lat);
        end
    endtask

    task automatic test_invalid();
        int lat, nb;
        run(40'h00000A0001, lat, nb);
        total++;
        if (bin !== 32'h0 || invalid !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL invalid got bin=%h inv=%b ovf=%b exp 0 1 0", bin, invalid, overflow);
        end
        run(40'h9999A99999, lat, nb);
        total++;
        if (bin !== 32'h0 || invalid !== 1'b1) begin
            bad++;
            $display("FAIL invalid_priority got bin=%h inv=%b exp 0 1", bin, invalid);
        end
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        @(negedge clk);
        bcd = 40'h0000000007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        bcd = 40'h0000000009;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 11 || bin !== 32'd7) begin
            bad++;
            $display("FAIL ignore_start got lat=%0d bin=%h exp 11 00000007", lat, bin);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignore_no_queue got=%0d active cycles exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bcd = 40'h0000000042;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 30);
        total++;
        if (lat !== 11 || bin !== 32'h0000002A) begin
            bad++;
            $display("FAIL b2b_first got lat=%0d bin=%h exp 11 0000002A", lat, bin);
        end
        bcd = 40'h1000000000;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 11 || bin !== 32'h3B9ACA00) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d bin=%h exp 11 3B9ACA00", lat, bin);
        end
    endtask

    task automatic test_async_reset();
        int lat, nb, seen;
        run(40'h9999999999, lat, nb);
        @(negedge clk);
        bcd = 40'h0000012345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, overflow, invalid} !== 4'b0 || bin !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b ovf=%b inv=%b bin=%h exp all 0", busy, done, overflow, invalid, bin);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", seen); end
        run(40'h0000012345, lat, nb);
        total++;
        if (lat !== 11 || bin !== 32'h00003039 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL after_reset got lat=%0d bin=%h ovf=%b exp 11 00003039 0", lat, bin, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary decoder: the inverse of the display path's binary-to-BCD converter. It turns a 10-digit decimal value typed by the user (n/e/d key entry) into the 32-bit binary key that the key manager and crypt engines consume. It processes one digit per clock using an accumulate step, acc = acc*10 + digit. It flags out-of-range values and non-decimal nibbles.

Parameters:
DIGITS, 10, number of BCD digits in the input; digit DIGITS-1 is the most significant.
BIN_W, 32, binary output width; the largest legal result is 2^BIN_W-1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; bcd is sampled when start is accepted
bcd  input  4*DIGITS  packed BCD, digit i at bits [4i+3:4i]
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse when bin, overflow and invalid are valid
bin  output  BIN_W  converted value; held until the next accepted start
overflow  output  1  decimal value > 2^BIN_W-1; held with bin
invalid  output  1  at least one nibble > 9; held with bin

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, bin=0, overflow=0, invalid=0, internal accumulator/shift register/counter=0. A reset mid-conversion aborts it with no done pulse.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1: latch bcd into a shift register, acc=0, cnt=0, clear sticky flags, go to CONV.
  - bin, overflow and invalid keep their previous values until DONE.
- CONV, every cycle:
  - d = top nibble of the shift register.
  - If d>9, set sticky invalid.
  - If neither flag is set, acc_next = acc*10 + d, computed BIN_W+4 bits wide.
    - If acc_next > 2^BIN_W-1, set sticky overflow and freeze acc.
    - Otherwise acc = acc_next.
  - Shift the register left 4; cnt++.
  - After the digit with cnt=DIGITS-1 is processed, go to DONE.
- DONE, single cycle:
  - done=1; busy=0; go to IDLE.
  - bin = 0 if invalid; else all-ones if overflow; else acc[BIN_W-1:0].
  - Invalid takes priority over overflow when both would apply.
- Latency: start accepted in cycle T; busy=1 in cycles T+1..T+DIGITS; done=1 in cycle T+DIGITS+1.
- start while busy, or in the DONE cycle, is ignored with no queuing.
- start held high re-triggers on the first IDLE cycle after DONE.
- Leading zeros are legal. All-zero input gives bin=0 with no flags.
- The accumulator never exceeds 10*(2^BIN_W-1)+9, which fits in BIN_W+4 bits.
- Outputs are registered; there is no combinational path from start/bcd to any output.

Decomposition:
- Shared package holds:
  - defaults DIGITS=10 and BIN_W=32
  - state encoding IDLE/CONV/DONE
  - BCD_MAX_DIGIT=4'd9
- One sub-module is natural: bcd_digit_mac. It is combinational and takes acc (BIN_W+4 bits) and d (4 bits).
  - Outputs: acc_next, ovf (acc_next > 2^BIN_W-1), bad (d > 9).
  - It isolates the multiply-by-10 (shift-and-add: acc<<3 + acc<<1) for separate unit testing.
- The FSM, counter and shift register stay in bcd_to_bin_seq.

Test Plan:
- bcd=40'h0000012345, start for 1 cycle -> busy for 10 cycles, done at T+11, bin=32'h00003039, overflow=0, invalid=0.
- bcd=40'h4294967295 -> bin=32'hFFFFFFFF, overflow=0, invalid=0. bcd=40'h4294967296 -> overflow=1, bin=32'hFFFFFFFF.
- bcd=40'h9999999999 -> overflow=1, bin=32'hFFFFFFFF; bcd=40'h0000000000 -> bin=0, no flags, done still at T+11.
- bcd=40'h00000A0001 -> invalid=1, bin=0. bcd=40'h9999A99999 (overflow and invalid both apply) -> invalid=1, bin=0.
- Conversion of 40'h0000000007 running; at T+4 pulse start with bcd=40'h0000000009 -> ignored; done at T+11, bin=7. Back-to-back starts on consecutive IDLE cycles both complete in order.
- Reset asserted asynchronously at T+5 mid-conversion -> busy/done/bin/flags=0 immediately, no done pulse. A new start after release converts correctly.
